// File: rtl/mem_arb_pkg.sv
// Types and constants shared by the line-transfer arbiter, the caches and the
// memory-controller wrapper.
package mem_arb_pkg;

    localparam int LINE_BITS   = 512;
    localparam int OFFSET_BITS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        CLI_IC = 1'b0,
        CLI_DC = 1'b1
    } client_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-client round-robin grant: a combinational pick from the request pair,
// plus the registered last-grant pointer used to break ties.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_ic,
    input  logic    req_dc,
    input  logic    grant_en,
    output logic    grant_valid,
    output client_e grant_id
);

    client_e last_grant;

    always_comb begin
        grant_valid = req_ic | req_dc;
        grant_id    = CLI_IC;
        if (req_ic && req_dc) begin
            if (last_grant == CLI_DC) begin
                grant_id = CLI_IC;
            end else begin
                grant_id = CLI_DC;
            end
        end else if (req_dc) begin
            grant_id = CLI_DC;
        end
    end

    // Resetting to the D-cache hands the first tie to the I-cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= CLI_DC;
        end else if (grant_en && grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory controller's single line-transfer port between the I-cache
// and D-cache, one transaction in flight; also forwards controller invalidates.
//
// state | meaning
// IDLE  | no transaction; client requests sampled and arbitrated
// BUSY  | latched request presented to the controller until mc_data_valid
// RESP  | one-cycle response pulse to the granted client
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int LINE_BITS   = mem_arb_pkg::LINE_BITS,
    parameter int OFFSET_BITS = mem_arb_pkg::OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_resp_valid,
    output logic [LINE_BITS-1:0]  ic_resp_data,
    input  logic                  dc_req,
    input  logic                  dc_we,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic [LINE_BITS-1:0]  dc_wdata,
    output logic                  dc_resp_valid,
    output logic [LINE_BITS-1:0]  dc_resp_data,
    output logic                  dc_invalidate,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [LINE_BITS-1:0]  mc_wdata,
    output logic                  mc_start_req,
    output logic                  mc_wr_en,
    input  logic [LINE_BITS-1:0]  mc_data,
    input  logic                  mc_data_valid,
    input  logic                  mc_invalidate
);

    import mem_arb_pkg::*;

    arb_state_e state, state_nxt;

    logic    grant_valid;
    logic    grant_en;
    logic    capture;
    client_e grant_id;

    client_e               lat_client;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [LINE_BITS-1:0]  lat_wdata;
    logic [LINE_BITS-1:0]  resp_q;

    rr_arbiter_2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_ic      (ic_req),
        .req_dc      (dc_req),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_en      = 1'b0;
        capture       = 1'b0;
        mc_start_req  = 1'b0;
        mc_wr_en      = 1'b0;
        mc_addr       = '0;
        mc_wdata      = '0;
        ic_resp_valid = 1'b0;
        dc_resp_valid = 1'b0;
        ic_resp_data  = '0;
        dc_resp_data  = '0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    grant_en  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Drop start in the completion cycle so the controller never re-issues.
                mc_start_req = ~mc_data_valid;
                mc_wr_en     = lat_we;
                mc_addr      = {lat_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                mc_wdata     = lat_wdata;
                if (mc_data_valid) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (lat_client == CLI_IC) begin
                    ic_resp_valid = 1'b1;
                    ic_resp_data  = resp_q;
                end else begin
                    dc_resp_valid = 1'b1;
                    dc_resp_data  = resp_q;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_client    <= CLI_IC;
            lat_addr      <= '0;
            lat_we        <= 1'b0;
            lat_wdata     <= '0;
            resp_q        <= '0;
            dc_invalidate <= 1'b0;
        end else begin
            dc_invalidate <= mc_invalidate;
            if (grant_en) begin
                lat_client <= grant_id;
                if (grant_id == CLI_DC) begin
                    lat_addr  <= dc_addr;
                    lat_we    <= dc_we;
                    lat_wdata <= dc_wdata;
                end else begin
                    lat_addr  <= ic_addr;
                    lat_we    <= 1'b0;
                    lat_wdata <= '0;
                end
            end
            // Write-backs return an all-zero line.
            if (capture) begin
                resp_q <= lat_we ? '0 : mc_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences, and randomized transactions against a transaction model.
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int LB = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_resp_valid;
    logic [LB-1:0] ic_resp_data;
    logic          dc_req;
    logic          dc_we;
    logic [AW-1:0] dc_addr;
    logic [LB-1:0] dc_wdata;
    logic          dc_resp_valid;
    logic [LB-1:0] dc_resp_data;
    logic          dc_invalidate;
    logic [AW-1:0] mc_addr;
    logic [LB-1:0] mc_wdata;
    logic          mc_start_req;
    logic          mc_wr_en;
    logic [LB-1:0] mc_data;
    logic          mc_data_valid;
    logic          mc_invalidate;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_BITS(LB), .OFFSET_BITS(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_resp_valid (ic_resp_valid),
        .ic_resp_data  (ic_resp_data),
        .dc_req        (dc_req),
        .dc_we         (dc_we),
        .dc_addr       (dc_addr),
        .dc_wdata      (dc_wdata),
        .dc_resp_valid (dc_resp_valid),
        .dc_resp_data  (dc_resp_data),
        .dc_invalidate (dc_invalidate),
        .mc_addr       (mc_addr),
        .mc_wdata      (mc_wdata),
        .mc_start_req  (mc_start_req),
        .mc_wr_en      (mc_wr_en),
        .mc_data       (mc_data),
        .mc_data_valid (mc_data_valid),
        .mc_invalidate (mc_invalidate)
    );

    typedef struct {
        bit            icr;
        bit            dcr;
        bit            we;
        bit            drop;
        logic [AW-1:0] ica;
        logic [AW-1:0] dca;
        logic [LB-1:0] wd;
        logic [LB-1:0] mcd;
        int            dly;
        bit            exp_dc;
        logic [AW-1:0] exp_addr;
        bit            exp_we;
        logic [LB-1:0] exp_wdata;
        logic [LB-1:0] exp_resp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    bit inv_rand = 1'b0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock; dc_invalidate must always equal last cycle's mc_invalidate (0 in reset).
    task automatic tick();
        logic exp_inv;
        exp_inv = rst ? 1'b0 : mc_invalidate;
        @(posedge clk);
        #1;
        chk1("dc_invalidate follow", dc_invalidate, exp_inv);
        if (inv_rand) mc_invalidate = 1'($urandom_range(0, 1));
    endtask

    task automatic chk_all_zero(input string nm);
        chk1({nm, " mc_start_req"}, mc_start_req, 1'b0);
        chk1({nm, " mc_wr_en"}, mc_wr_en, 1'b0);
        chka({nm, " mc_addr"}, mc_addr, '0);
        chkw({nm, " mc_wdata"}, mc_wdata, '0);
        chk1({nm, " ic_resp_valid"}, ic_resp_valid, 1'b0);
        chk1({nm, " dc_resp_valid"}, dc_resp_valid, 1'b0);
        chkw({nm, " ic_resp_data"}, ic_resp_data, '0);
        chkw({nm, " dc_resp_data"}, dc_resp_data, '0);
        chk1({nm, " dc_invalidate"}, dc_invalidate, 1'b0);
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] v;
        v = '0;
        for (int i = 0; i < LB / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic vec_t mk(input bit icr, input bit dcr, input bit we, input bit drop,
                                input logic [AW-1:0] ica, input logic [AW-1:0] dca,
                                input logic [LB-1:0] wd, input logic [LB-1:0] mcd, input int dly,
                                input bit exp_dc, input logic [AW-1:0] exp_addr, input bit exp_we,
                                input logic [LB-1:0] exp_wdata, input logic [LB-1:0] exp_resp);
        vec_t v;
        v.icr = icr; v.dcr = dcr; v.we = we; v.drop = drop;
        v.ica = ica; v.dca = dca; v.wd = wd; v.mcd = mcd; v.dly = dly;
        v.exp_dc = exp_dc; v.exp_addr = exp_addr; v.exp_we = exp_we;
        v.exp_wdata = exp_wdata; v.exp_resp = exp_resp;
        return v;
    endfunction

    // Entered in an IDLE cycle; returns in the IDLE cycle after the response.
    task automatic run_txn(input string nm, input bit icr, input bit dcr, input logic [AW-1:0] ica,
                           input bit we, input logic [AW-1:0] dca, input logic [LB-1:0] wd,
                           input logic [LB-1:0] mcd, input int dly, input bit drop, input bit hold,
                           input bit inv_pulse, input bit exp_dc, input logic [AW-1:0] exp_addr,
                           input bit exp_we, input logic [LB-1:0] exp_wdata,
                           input logic [LB-1:0] exp_resp);
        ic_req = icr; dc_req = dcr; ic_addr = ica; dc_we = we; dc_addr = dca; dc_wdata = wd;
        tick();
        chk1({nm, " start after grant"}, mc_start_req, 1'b1);
        chka({nm, " mc_addr"}, mc_addr, exp_addr);
        chk1({nm, " mc_wr_en"}, mc_wr_en, exp_we);
        chkw({nm, " mc_wdata"}, mc_wdata, exp_wdata);
        ic_addr = ~ica; dc_addr = ~dca; dc_wdata = ~wd; dc_we = ~we;
        if (drop) begin
            ic_req = 1'b0;
            dc_req = 1'b0;
        end
        if (inv_pulse) mc_invalidate = 1'b1;
        for (int i = 0; i < dly; i++) begin
            tick();
            if (inv_pulse && i == 0) begin
                chk1({nm, " invalidate pulse"}, dc_invalidate, 1'b1);
                mc_invalidate = 1'b0;
            end
            chk1({nm, " start held"}, mc_start_req, 1'b1);
            chka({nm, " mc_addr held"}, mc_addr, exp_addr);
        end
        mc_data = mcd;
        mc_data_valid = 1'b1;
        #1;
        chk1({nm, " start drop"}, mc_start_req, 1'b0);
        tick();
        mc_data_valid = 1'b0;
        mc_data = rand_line();
        chk1({nm, " ic_resp_valid"}, ic_resp_valid, !exp_dc);
        chk1({nm, " dc_resp_valid"}, dc_resp_valid, exp_dc);
        chkw({nm, " resp_data"}, exp_dc ? dc_resp_data : ic_resp_data, exp_resp);
        chk1({nm, " start in resp"}, mc_start_req, 1'b0);
        if (!hold) begin
            ic_req = 1'b0;
            dc_req = 1'b0;
        end
        tick();
        chk1({nm, " ic pulse end"}, ic_resp_valid, 1'b0);
        chk1({nm, " dc pulse end"}, dc_resp_valid, 1'b0);
        chk1({nm, " start idle"}, mc_start_req, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[8];
        logic [LB-1:0] p1, p2, a5, mcd, wd;
        logic [AW-1:0] ica, dca, ea;
        bit            last_dc, exp_dc, icr, dcr, we, drop;
        int            r;

        p1 = {16{32'hDEAD_BEEF}};
        p2 = {8{64'h0123_4567_89AB_CDEF}};
        a5 = {64{8'hA5}};

        rst = 1'b1; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
        dc_addr = '0; dc_wdata = '0; mc_data = '0; mc_data_valid = 1'b0; mc_invalidate = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Completion pulse with nothing in flight must be ignored.
        mc_data = p1;
        mc_data_valid = 1'b1;
        #1;
        chk1("stray valid start", mc_start_req, 1'b0);
        tick();
        mc_data_valid = 1'b0;
        chk1("stray valid ic", ic_resp_valid, 1'b0);
        chk1("stray valid dc", dc_resp_valid, 1'b0);
        tick();
        chk1("stray valid ic late", ic_resp_valid, 1'b0);
        chk1("stray valid dc late", dc_resp_valid, 1'b0);

        tbl[0] = mk(1, 0, 0, 0, 64'h1000_0047, 64'h0, '0, p1, 2, 0, 64'h1000_0040, 0, '0, p1);
        tbl[1] = mk(0, 1, 1, 0, 64'h0, 64'h2000_0080, a5, p2, 1, 1, 64'h2000_0080, 1, a5, '0);
        tbl[2] = mk(1, 1, 0, 0, 64'h3000_007F, 64'h4000_0001, p2, p1, 0, 0, 64'h3000_0040, 0, '0, p1);
        tbl[3] = mk(1, 1, 1, 0, 64'h3000_0000, 64'h5000_00C5, p1, p2, 3, 1, 64'h5000_00C0, 1, p1, '0);
        tbl[4] = mk(0, 1, 0, 1, 64'h0, 64'h6000_0FFF, p2, p1, 1, 1, 64'h6000_0FC0, 0, p2, p1);
        tbl[5] = mk(0, 1, 0, 0, 64'h0, 64'h7000_0040, '0, p2, 0, 1, 64'h7000_0040, 0, '0, p2);
        tbl[6] = mk(1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, p1, p2, 1, 0,
                    64'hFFFF_FFFF_FFFF_FFC0, 0, '0, p2);
        tbl[7] = mk(1, 0, 0, 0, 64'h0, 64'h0, '0, p1, 0, 0, 64'h0, 0, '0, p1);

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].icr, tbl[i].dcr, tbl[i].ica, tbl[i].we,
                    tbl[i].dca, tbl[i].wd, tbl[i].mcd, tbl[i].dly, tbl[i].drop, 1'b0, 1'b0,
                    tbl[i].exp_dc, tbl[i].exp_addr, tbl[i].exp_we, tbl[i].exp_wdata,
                    tbl[i].exp_resp);
        end

        run_txn("inval", 0, 1, 64'h0, 0, 64'h8000_0100, p2, p1, 2, 0, 0, 1,
                1, 64'h8000_0100, 0, p2, p1);

        // Reset in the middle of an I-cache transaction.
        ic_req = 1'b1;
        ic_addr = 64'h9000_0010;
        tick();
        chk1("pre-reset start", mc_start_req, 1'b1);
        rst = 1'b1;
        tick();
        chk_all_zero("mid-busy reset");
        ic_req = 1'b0;
        tick();
        chk1("reset no ic pulse", ic_resp_valid, 1'b0);
        chk1("reset no dc pulse", dc_resp_valid, 1'b0);
        rst = 1'b0;
        tick();

        // Both held high across four transactions: I, D, I, D.
        for (int k = 0; k < 4; k++) begin
            ica = 64'hA000_0000 + 64'(k) * 64'h100;
            dca = 64'hB000_0000 + 64'(k) * 64'h100;
            mcd = rand_line();
            exp_dc = (k % 2) == 1;
            run_txn($sformatf("tie%0d", k), 1, 1, ica, 0, dca, '0, mcd, k % 3, 0, 1, 0,
                    exp_dc, exp_dc ? dca : ica, 0, '0, mcd);
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        last_dc = 1'b1;
        inv_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(1, 3);
            icr = r[0];
            dcr = r[1];
            we = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 3) == 0);
            ica = {$urandom, $urandom};
            dca = {$urandom, $urandom};
            wd = rand_line();
            mcd = rand_line();
            if (icr && dcr) exp_dc = !last_dc;
            else exp_dc = dcr;
            last_dc = exp_dc;
            ea = (exp_dc ? dca : ica) & ~64'h3F;
            run_txn($sformatf("rnd%0d", n), icr, dcr, ica, we, dca, wd, mcd,
                    $urandom_range(0, 3), drop, 0, 0, exp_dc, ea, exp_dc & we,
                    exp_dc ? wd : '0, (exp_dc & we) ? '0 : mcd);
        end
        inv_rand = 1'b0;
        mc_invalidate = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
